// File: rtl/qspi_flash_sequencer.sv
// qspi_flash_sequencer
//
// Serves 32-bit reads from a memory-mapped QSPI flash to two requesters.
// p0 is the instruction fetch port and p1 is the data port. Each read
// uses three Wishbone accesses to the SPI controller register file:
//   1. Write the flash address register (0x04).
//   2. Write the command/configuration register (0x00). The slave holds
//      back its ack until the flash transfer has finished.
//   3. Read the data register (0x08).
// The word from the data register is byte-swapped and returned on the
// owner's dat_o, along with a one-cycle ack_o.
//
// Ports
//   clk_i, rst_ni            clock; asynchronous active-low reset
//   pN_req_i / pN_addr_i     read request and flash byte address; the
//                            request is held until the matching ack
//   pN_ack_o / pN_err_o      one-cycle completion pulse; err_o marks a
//                            timeout
//   pN_dat_o                 read word; zero whenever ack is low
//   wbm_*                    Wishbone master to the SPI controller
//   busy_o                   high while a read is in flight
module qspi_flash_sequencer #(
    parameter logic [7:0]  READ_CMD  = 8'h6B,
    parameter logic [4:0]  DUMMY_CYC = 5'd8,
    parameter logic [5:0]  PRESCALE  = 6'd3,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        p0_req_i,
    input  logic [23:0] p0_addr_i,
    output logic        p0_ack_o,
    output logic        p0_err_o,
    output logic [31:0] p0_dat_o,
    input  logic        p1_req_i,
    input  logic [23:0] p1_addr_i,
    output logic        p1_ack_o,
    output logic        p1_err_o,
    output logic [31:0] p1_dat_o,
    output logic [7:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_ADR = 3'd1;
    localparam logic [2:0] WR_CCR = 3'd2;
    localparam logic [2:0] RD_DAT = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    localparam logic [7:0] REG_CCR = 8'h00;
    localparam logic [7:0] REG_AR  = 8'h04;
    localparam logic [7:0] REG_DR  = 8'h08;

    // Command/configuration word: 4-line data, 1-line instruction, 1-line
    // address, 24-bit address size, plus the dummy cycles and prescaler.
    localparam logic [31:0] CCR_WORD = {1'b0, PRESCALE, 9'd3, DUMMY_CYC,
                                        1'b0, 2'b11, READ_CMD};

    // The flash returns bytes in ascending address order, but the data
    // register packs the first byte in the top lane. Swap the bytes back
    // so the lowest address sits in bits [7:0].
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [2:0]  state_q, state_d;
    logic        gap_q, gap_d;       // one idle bus cycle before a new access
    logic        owner_q, owner_d;   // 0 = p0, 1 = p1
    logic        last_q, last_d;     // last port served, used for round-robin
    logic        err_q, err_d;
    logic [23:0] addr_q, addr_d;     // word-aligned byte address
    logic [31:0] data_q, data_d;
    logic [15:0] wait_q, wait_d;

    logic in_bus;
    logic timed_out;
    logic stb;
    logic bus_ack;
    logic grant;
    logic resp;

    assign in_bus    = (state_q == WR_ADR) || (state_q == WR_CCR) ||
                       (state_q == RD_DAT);
    assign timed_out = (wait_q == TIMEOUT);
    // The strobe drops for the gap cycle and once the wait budget runs out.
    assign stb       = in_bus && !gap_q && !timed_out;
    // An ack is accepted only while the strobe is high.
    assign bus_ack   = stb && wbm_ack_i;
    // If both ports request, the port that was not served last wins.
    // Otherwise the only requester wins.
    assign grant     = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;

    always_comb begin
        state_d = state_q;
        gap_d   = 1'b0;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    owner_d = grant;
                    addr_d  = (grant ? p1_addr_i : p0_addr_i) & 24'hFFFFFC;
                    err_d   = 1'b0;
                    data_d  = 32'h0;
                    state_d = WR_ADR;
                end
            end
            WR_ADR: begin
                if (timed_out) begin
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = RESP;
                end else if (bus_ack) begin
                    gap_d   = 1'b1;
                    state_d = WR_CCR;
                end
            end
            WR_CCR: begin
                if (timed_out) begin
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = RESP;
                end else if (bus_ack) begin
                    gap_d   = 1'b1;
                    state_d = RD_DAT;
                end
            end
            RD_DAT: begin
                if (timed_out) begin
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = RESP;
                end else if (bus_ack) begin
                    data_d  = byte_swap(wbm_dat_i);
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The wait counter restarts at each state entry. It counts only the
    // strobed cycles in which the slave has not answered.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = 16'h0;
        end else if (stb && !wbm_ack_i) begin
            wait_d = wait_q + 16'h1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gap_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            addr_q  <= 24'h0;
            data_q  <= 32'h0;
            wait_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        wbm_adr_o = 8'h00;
        wbm_dat_o = 32'h0;
        case (state_q)
            WR_ADR: begin
                wbm_adr_o = REG_AR;
                wbm_dat_o = {8'h00, addr_q};
            end
            WR_CCR: begin
                wbm_adr_o = REG_CCR;
                wbm_dat_o = CCR_WORD;
            end
            RD_DAT: wbm_adr_o = REG_DR;
            default: begin
                wbm_adr_o = 8'h00;
                wbm_dat_o = 32'h0;
            end
        endcase
    end

    assign wbm_we_o  = (state_q == WR_ADR) || (state_q == WR_CCR);
    assign wbm_sel_o = in_bus ? 4'hF : 4'h0;
    assign wbm_stb_o = stb;
    assign wbm_cyc_o = stb;

    assign resp     = (state_q == RESP);
    assign p0_ack_o = resp && !owner_q;
    assign p1_ack_o = resp && owner_q;
    assign p0_err_o = p0_ack_o && err_q;
    assign p1_err_o = p1_ack_o && err_q;
    assign p0_dat_o = p0_ack_o ? data_q : 32'h0;
    assign p1_dat_o = p1_ack_o ? data_q : 32'h0;
    assign busy_o   = (state_q != IDLE);

endmodule
